// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with the 0x80 marker, zero fill and 64-bit length.
// Optional zero-length message support via SHA256_PADDER_ZERO_LEN_EN (adds in_empty).
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
`ifdef SHA256_PADDER_ZERO_LEN_EN
    input  logic         in_empty,
`endif
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        OUT_DATA = 2'd1,
        OUT_TAIL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [5:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               tail_pend_q, tail_pend_d;
    logic               tail_80_q, tail_80_d;
    logic               last_q, last_d;
    logic               first_pend_q, first_pend_d;

    logic               accept;
    logic               empty_beat;
    logic [LEN_W-1:0]   len_acc;
    logic [6:0]         pad_pos;

`ifdef SHA256_PADDER_ZERO_LEN_EN
    assign empty_beat = in_empty & in_last;
`else
    assign empty_beat = 1'b0;
`endif

    assign accept  = in_valid & (state_q == FILL);
    // An empty final beat pads at idx as if the previous byte had been the last one.
    assign len_acc = empty_beat ? len_q : len_q + LEN_W'(8);
    assign pad_pos = empty_beat ? {1'b0, idx_q} : {1'b0, idx_q} + 7'd1;

    // NOTE: every next-state variable gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        len_d        = len_q;
        tail_pend_d  = tail_pend_q;
        tail_80_d    = tail_80_q;
        last_d       = last_q;
        first_pend_d = first_pend_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (!empty_beat) begin
                        for (int i = 0; i < 64; i++) begin
                            if (idx_q == 6'(i)) buf_d[511-8*i -: 8] = in_data;
                        end
                    end
                    len_d = len_acc;
                    idx_d = idx_q + 6'd1;
                    if (in_last) begin
                        for (int i = 0; i < 64; i++) begin
                            if (pad_pos == 7'(i)) buf_d[511-8*i -: 8] = 8'h80;
                        end
                        if (pad_pos <= 7'd55) begin
                            buf_d[63:0] = 64'(len_acc);
                            last_d      = 1'b1;
                            tail_pend_d = 1'b0;
                        end else begin
                            // Marker and/or length spill into an extra all-padding block.
                            last_d      = 1'b0;
                            tail_pend_d = 1'b1;
                            tail_80_d   = (pad_pos == 7'd64);
                        end
                        state_d = OUT_DATA;
                    end else if (idx_q == 6'd63) begin
                        last_d      = 1'b0;
                        tail_pend_d = 1'b0;
                        state_d     = OUT_DATA;
                    end
                end
            end

            OUT_DATA: begin
                if (blk_ready) begin
                    first_pend_d = 1'b0;
                    buf_d        = '0;
                    if (tail_pend_q) begin
                        if (tail_80_q) buf_d[511:504] = 8'h80;
                        buf_d[63:0] = 64'(len_q);
                        state_d     = OUT_TAIL;
                    end else begin
                        idx_d   = '0;
                        state_d = FILL;
                        if (last_q) begin
                            len_d        = '0;
                            last_d       = 1'b0;
                            first_pend_d = 1'b1;
                        end
                    end
                end
            end

            OUT_TAIL: begin
                if (blk_ready) begin
                    buf_d        = '0;
                    idx_d        = '0;
                    len_d        = '0;
                    tail_pend_d  = 1'b0;
                    tail_80_d    = 1'b0;
                    last_d       = 1'b0;
                    first_pend_d = 1'b1;
                    state_d      = FILL;
                end
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: the block buffer is a plain register bank, so it is reset with everything else; blk_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            buf_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            tail_pend_q  <= 1'b0;
            tail_80_q    <= 1'b0;
            last_q       <= 1'b0;
            first_pend_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            tail_pend_q  <= tail_pend_d;
            tail_80_q    <= tail_80_d;
            last_q       <= last_d;
            first_pend_q <= first_pend_d;
        end
    end

    // Outputs decode registered state only; nothing depends combinationally on blk_ready.
    assign in_ready  = (state_q == FILL);
    assign blk_valid = (state_q == OUT_DATA) || (state_q == OUT_TAIL);
    assign blk_data  = buf_q;
    assign blk_first = blk_valid & first_pend_q;
    assign blk_last  = (state_q == OUT_TAIL) || ((state_q == OUT_DATA) && last_q);

endmodule

// File: tb/tb_sha256_padder.sv
// Directed self-checking bench for sha256_padder; build with SHA256_PADDER_ZERO_LEN_EN to cover empty messages.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_empty = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int           checks = 0;
    int           errors = 0;
    logic [511:0] exp_blk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef SHA256_PADDER_ZERO_LEN_EN
        .in_empty  (in_empty),
`endif
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input int i, input logic [7:0] v);
        exp_blk[511-8*i -: 8] = v;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_empty = e;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {511'b0, in_ready}, 512'd1);
        @(posedge clk); #1;
        if (l) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_empty = 1'b0;
        end
    endtask

    task automatic send_fill(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send_beat(d, (i == n - 1), 1'b0);
    endtask

    task automatic send_abc();
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
    endtask

    task automatic get_block(input string tag, input logic ef, input logic el);
        int guard;
        guard = 0;
        while (!blk_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_valid"}, {511'b0, blk_valid}, 512'd1);
        check({tag, "_data"}, blk_data, exp_blk);
        check({tag, "_first"}, {511'b0, blk_first}, {511'b0, ef});
        check({tag, "_last"}, {511'b0, blk_last}, {511'b0, el});
        if (blk_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic exp_abc();
        exp_blk = '0;
        put_byte(0, 8'h61);
        put_byte(1, 8'h62);
        put_byte(2, 8'h63);
        put_byte(3, 8'h80);
        exp_blk[63:0] = 64'h18;
    endtask

    initial begin
        #12;
        check("rst_in_ready", {511'b0, in_ready}, 512'd1);
        check("rst_blk_valid", {511'b0, blk_valid}, 512'd0);
        check("rst_blk_data", blk_data, 512'd0);
        check("rst_flags", {510'b0, blk_first, blk_last}, 512'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // abc, one block, valid the cycle after the final accept
        send_abc();
        check("t1_latency", {511'b0, blk_valid}, 512'd1);
        exp_abc();
        get_block("t1", 1'b1, 1'b1);
        check("t1_back_to_fill", {511'b0, in_ready}, 512'd1);

        // 55 zero bytes: marker at 55, length fits
        send_fill(8'h00, 55);
        exp_blk = '0;
        put_byte(55, 8'h80);
        exp_blk[63:0] = 64'h1b8;
        get_block("t2", 1'b1, 1'b1);

        // 56 bytes: marker in block 1, length in tail block
        send_fill(8'h41, 56);
        exp_blk = '0;
        for (int i = 0; i < 56; i++) put_byte(i, 8'h41);
        put_byte(56, 8'h80);
        get_block("t3a", 1'b1, 1'b0);
        exp_blk = '0;
        exp_blk[63:0] = 64'h1c0;
        get_block("t3b", 1'b0, 1'b1);

        // 64 bytes: marker and length both in tail block
        send_fill(8'hff, 64);
        exp_blk = '1;
        get_block("t4a", 1'b1, 1'b0);
        exp_blk = '0;
        put_byte(0, 8'h80);
        exp_blk[63:0] = 64'h200;
        get_block("t4b", 1'b0, 1'b1);

        // backpressure: block held stable, input stalled
        blk_ready = 1'b0;
        send_abc();
        exp_abc();
        for (int c = 0; c < 5; c++) begin
            check("t5_hold_data", blk_data, exp_blk);
            check("t5_hold_valid", {511'b0, blk_valid}, 512'd1);
            check("t5_hold_in_ready", {511'b0, in_ready}, 512'd0);
            @(posedge clk); #1;
        end
        blk_ready = 1'b1;
        get_block("t5_release", 1'b1, 1'b1);
        send_abc();
        get_block("t5_msg1", 1'b1, 1'b1);
        send_abc();
        get_block("t5_msg2", 1'b1, 1'b1);

`ifdef SHA256_PADDER_ZERO_LEN_EN
        send_beat(8'h55, 1'b1, 1'b1);
        exp_blk = '0;
        put_byte(0, 8'h80);
        get_block("t6_empty", 1'b1, 1'b1);
`endif

        // asynchronous reset while a block is pending
        blk_ready = 1'b0;
        send_fill(8'h11, 64);
        check("t6_pre_rst_valid", {511'b0, blk_valid}, 512'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {511'b0, blk_valid}, 512'd0);
        check("t6_rst_in_ready", {511'b0, in_ready}, 512'd1);
        check("t6_rst_data", blk_data, 512'd0);
        #2 rst_n = 1'b1;
        blk_ready = 1'b1;
        @(posedge clk); #1;
        send_abc();
        exp_abc();
        get_block("t6_after_rst", 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
